// File: rtl/gen1_tx_scheduler.sv
// Gen1/Gen2 transmit symbol scheduler feeding the scrambler: arbitrates SKP ordered sets,
// LTSSM ordered sets and link-layer packet beats, filling gaps with logical idle.
module gen1_tx_scheduler #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  data_k_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    output logic        data_ready_o,
    input  logic        os_req_i,
    input  logic [1:0]  os_type_i,
    input  logic [7:0]  link_num_i,
    input  logic [7:0]  lane_num_i,
    input  logic [7:0]  n_fts_i,
    input  logic [7:0]  rate_id_i,
    input  logic [7:0]  train_ctrl_i,
    input  logic        link_pad_i,
    input  logic        lane_pad_i,
    output logic        os_ack_o,
    output logic [31:0] data_out_o,
    output logic [3:0]  data_k_out_o,
    output logic        data_valid_o,
    output logic        tx_elec_idle_o,
    output logic        underflow_o
);

    typedef enum logic [2:0] {
        ST_EI,
        ST_IDLE,
        ST_DATA,
        ST_TS,
        ST_SKP,
        ST_EIOS
    } state_t;

    localparam logic [7:0]  SYM_COM   = 8'hBC;
    localparam logic [7:0]  SYM_SKP   = 8'h1C;
    localparam logic [7:0]  SYM_IDL   = 8'h7C;
    localparam logic [7:0]  SYM_PAD   = 8'hF7;
    localparam logic [7:0]  TS1_ID    = 8'h4A;
    localparam logic [7:0]  TS2_ID    = 8'h45;
    localparam logic [10:0] SKP_LIMIT = 11'(SKP_INTERVAL);
    localparam logic [10:0] CNT_MAX   = 11'h7FF;

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  id_q, id_d;
    logic [7:0]  rate_q, rate_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  k_q, k_d;
    logic        valid_q, valid_d;
    logic        eidle_q, eidle_d;
    logic        ack_q, ack_d;
    logic        uflow_q, uflow_d;

    logic        skp_pending;
    logic        os_ok;
    logic        boundary;
    logic [7:0]  sel_id;
    logic [31:0] ts0_data;
    logic [3:0]  ts0_k;

    assign skp_pending = (cnt_q >= SKP_LIMIT);
    // The requester drops os_req_i only after seeing the ack, so ignore it for that one cycle.
    assign os_ok       = os_req_i && (os_type_i != 2'b11) && !ack_q;
    assign boundary    = (state_q == ST_IDLE) || (state_q == ST_SKP) ||
                         ((state_q == ST_TS) && (beat_q == 2'd3));
    assign sel_id      = os_type_i[0] ? TS2_ID : TS1_ID;
    assign ts0_data    = {n_fts_i,
                          lane_pad_i ? SYM_PAD : lane_num_i,
                          link_pad_i ? SYM_PAD : link_num_i,
                          SYM_COM};
    assign ts0_k       = {1'b0, lane_pad_i, link_pad_i, 1'b1};

    assign data_ready_o = (state_q == ST_DATA) ||
                          ((state_q == ST_IDLE) && !skp_pending && !os_req_i);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        id_d    = id_q;
        rate_d  = rate_q;
        ctrl_d  = ctrl_q;
        data_d  = 32'h0;
        k_d     = 4'h0;
        valid_d = 1'b1;
        eidle_d = 1'b0;
        ack_d   = 1'b0;
        uflow_d = 1'b0;

        case (state_q)
            ST_EI: begin
                valid_d = 1'b0;
                eidle_d = 1'b1;
                if (os_ok) begin
                    ack_d = 1'b1;
                    if (!os_type_i[1]) begin
                        data_d  = ts0_data;
                        k_d     = ts0_k;
                        valid_d = 1'b1;
                        eidle_d = 1'b0;
                        state_d = ST_TS;
                        beat_d  = 2'd0;
                        id_d    = sel_id;
                        rate_d  = rate_id_i;
                        ctrl_d  = train_ctrl_i;
                    end
                end
            end
            ST_DATA: begin
                if (data_valid_i) begin
                    data_d = data_i;
                    k_d    = data_k_i;
                    if (data_last_i) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    uflow_d = 1'b1;
                end
            end
            ST_TS: begin
                if (beat_q != 2'd3) begin
                    beat_d = beat_q + 2'd1;
                    data_d = (beat_q == 2'd0) ? {id_q, id_q, ctrl_q, rate_q} : {4{id_q}};
                end
            end
            ST_EIOS: begin
                valid_d = 1'b0;
                eidle_d = 1'b1;
                state_d = ST_EI;
            end
            default: ;
        endcase

        // Next-beat selection: SKP beats OS, OS beats packet data, otherwise logical idle.
        if (boundary) begin
            state_d = ST_IDLE;
            if (skp_pending) begin
                data_d  = {SYM_SKP, SYM_SKP, SYM_SKP, SYM_COM};
                k_d     = 4'hF;
                state_d = ST_SKP;
            end else if (os_ok) begin
                ack_d = 1'b1;
                if (!os_type_i[1]) begin
                    data_d  = ts0_data;
                    k_d     = ts0_k;
                    state_d = ST_TS;
                    beat_d  = 2'd0;
                    id_d    = sel_id;
                    rate_d  = rate_id_i;
                    ctrl_d  = train_ctrl_i;
                end else begin
                    data_d  = {SYM_IDL, SYM_IDL, SYM_IDL, SYM_COM};
                    k_d     = 4'hF;
                    state_d = ST_EIOS;
                end
            end else if (data_ready_o && data_valid_i) begin
                data_d  = data_i;
                k_d     = data_k_i;
                state_d = data_last_i ? ST_IDLE : ST_DATA;
            end
        end

        if ((state_d == ST_EI) || (state_d == ST_SKP)) begin
            cnt_d = 11'd0;
        end else if (valid_d) begin
            cnt_d = (cnt_q > (CNT_MAX - 11'd4)) ? CNT_MAX : (cnt_q + 11'd4);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EI;
            beat_q  <= 2'd0;
            cnt_q   <= 11'd0;
            id_q    <= 8'h0;
            rate_q  <= 8'h0;
            ctrl_q  <= 8'h0;
            data_q  <= 32'h0;
            k_q     <= 4'h0;
            valid_q <= 1'b0;
            eidle_q <= 1'b1;
            ack_q   <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rate_q  <= rate_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            eidle_q <= eidle_d;
            ack_q   <= ack_d;
            uflow_q <= uflow_d;
        end
    end

    assign data_out_o     = data_q;
    assign data_k_out_o   = k_q;
    assign data_valid_o   = valid_q;
    assign tx_elec_idle_o = eidle_q;
    assign os_ack_o       = ack_q;
    assign underflow_o    = uflow_q;

endmodule

// File: tb/tb_gen1_tx_scheduler.sv
// Self-checking bench for gen1_tx_scheduler: scenario tasks with randomized fields and
// packet contents, checked against expected symbol streams derived from the protocol rules.
module tb_gen1_tx_scheduler;

    localparam int SKP_INTERVAL = 1180;
    localparam int SKP_GAP      = SKP_INTERVAL / 4;
    localparam logic [35:0] SKP_BEAT  = {4'hF, 32'h1C1C1CBC};
    localparam logic [35:0] EIOS_BEAT = {4'hF, 32'h7C7C7CBC};
    localparam logic [35:0] IDLE_BEAT = 36'h0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic [3:0]  data_k_i;
    logic        data_valid_i;
    logic        data_last_i;
    logic        data_ready_o;
    logic        os_req_i;
    logic [1:0]  os_type_i;
    logic [7:0]  link_num_i, lane_num_i, n_fts_i, rate_id_i, train_ctrl_i;
    logic        link_pad_i, lane_pad_i;
    logic        os_ack_o;
    logic [31:0] data_out_o;
    logic [3:0]  data_k_out_o;
    logic        data_valid_o;
    logic        tx_elec_idle_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    gen1_tx_scheduler #(.SKP_INTERVAL(SKP_INTERVAL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .data_i(data_i), .data_k_i(data_k_i), .data_valid_i(data_valid_i),
        .data_last_i(data_last_i), .data_ready_o(data_ready_o),
        .os_req_i(os_req_i), .os_type_i(os_type_i),
        .link_num_i(link_num_i), .lane_num_i(lane_num_i), .n_fts_i(n_fts_i),
        .rate_id_i(rate_id_i), .train_ctrl_i(train_ctrl_i),
        .link_pad_i(link_pad_i), .lane_pad_i(lane_pad_i),
        .os_ack_o(os_ack_o), .data_out_o(data_out_o), .data_k_out_o(data_k_out_o),
        .data_valid_o(data_valid_o), .tx_elec_idle_o(tx_elec_idle_o),
        .underflow_o(underflow_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected {k, data} of TS beat b built straight from the ordered-set layout.
    function automatic logic [35:0] ts_beat(input logic ts2, input logic [7:0] n_fts,
                                            input logic [7:0] link, input logic [7:0] lane,
                                            input logic [7:0] rate, input logic [7:0] ctrl,
                                            input logic link_pad, input logic lane_pad,
                                            input int b);
        logic [7:0] id, link_sym, lane_sym;
        id       = ts2 ? 8'h45 : 8'h4A;
        link_sym = link_pad ? 8'hF7 : link;
        lane_sym = lane_pad ? 8'hF7 : lane;
        if (b == 0) return {1'b0, lane_pad, link_pad, 1'b1, n_fts, lane_sym, link_sym, 8'hBC};
        if (b == 1) return {4'h0, id, id, ctrl, rate};
        return {4'h0, id, id, id, id};
    endfunction

    task automatic idle_inputs();
        data_i = 32'h0; data_k_i = 4'h0; data_valid_i = 1'b0; data_last_i = 1'b0;
        os_req_i = 1'b0; os_type_i = 2'b00;
        link_num_i = 8'h0; lane_num_i = 8'h0; n_fts_i = 8'h0; rate_id_i = 8'h0;
        train_ctrl_i = 8'h0; link_pad_i = 1'b0; lane_pad_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Leave EI with a random TS1 and settle in logical idle.
    task automatic go_active();
        do_reset();
        os_req_i = 1'b1; os_type_i = 2'b00;
        link_num_i = 8'($urandom); lane_num_i = 8'($urandom); n_fts_i = 8'($urandom);
        tick();
        checks++;
        if (os_ack_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL go_active_ack: got %b expected 1", os_ack_o);
        end
        os_req_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_skp(input string name, output logic found);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (data_valid_o && {data_k_out_o, data_out_o} == SKP_BEAT) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s: got no SKP beat within 400 cycles, expected one", name);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        data_valid_i = 1'b1; data_i = $urandom; os_req_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({data_out_o, data_k_out_o, data_valid_o, tx_elec_idle_o, os_ack_o, underflow_o, data_ready_o}
            !== {32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got data=%h k=%h v=%b ei=%b ack=%b uf=%b rdy=%b expected 0 0 0 1 0 0 0",
                     data_out_o, data_k_out_o, data_valid_o, tx_elec_idle_o, os_ack_o, underflow_o, data_ready_o);
        end
        // Reset in the middle of a TS set abandons it and returns to EI.
        do_reset();
        os_req_i = 1'b1; os_type_i = 2'b00;
        tick();
        os_req_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({data_valid_o, tx_elec_idle_o, os_ack_o} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL reset_mid_ts: got v/ei/ack=%b%b%b expected 010", data_valid_o, tx_elec_idle_o, os_ack_o);
        end
        tick();
        checks++;
        if ({data_valid_o, tx_elec_idle_o, os_ack_o} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL after_reset_mid_ts: got v/ei/ack=%b%b%b expected 010", data_valid_o, tx_elec_idle_o, os_ack_o);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        logic [35:0] exp_beat;
        logic exp_ack, exp_rdy;
        do_reset();
        os_req_i = 1'b1; os_type_i = 2'b00;
        link_num_i = 8'h05; lane_num_i = 8'h02; n_fts_i = 8'h10; rate_id_i = 8'h02; train_ctrl_i = 8'h00;
        acks = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp_ack  = (c == 1) || (c == 5);
            exp_rdy  = (c == 9);
            exp_beat = (c <= 8) ? ts_beat(1'b0, 8'h10, 8'h05, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, (c - 1) % 4)
                                : IDLE_BEAT;
            checks++;
            if ({os_ack_o, data_valid_o, tx_elec_idle_o, data_ready_o, data_k_out_o, data_out_o}
                !== {exp_ack, 1'b1, 1'b0, exp_rdy, exp_beat}) begin
                errors++;
                $display("[TB] FAIL ts1_cycle%0d: got ack=%b v=%b ei=%b rdy=%b k=%h d=%h expected ack=%b v=1 ei=0 rdy=%b k=%h d=%h",
                         c, os_ack_o, data_valid_o, tx_elec_idle_o, data_ready_o, data_k_out_o, data_out_o,
                         exp_ack, exp_rdy, exp_beat[35:32], exp_beat[31:0]);
            end
            if (c == 1) begin
                checks++;
                if ({data_k_out_o, data_out_o} !== {4'h1, 32'h100205BC}) begin
                    errors++;
                    $display("[TB] FAIL ts1_beat0_const: got %h expected 1100205bc", {data_k_out_o, data_out_o});
                end
            end
            if (os_ack_o) acks++;
            if (acks == 2) os_req_i = 1'b0;
        end
    endtask

    task automatic test_ts2_pad();
        logic [7:0] nf, lk, ln, rt, ct;
        logic [35:0] exp_beat;
        do_reset();
        nf = 8'($urandom); lk = 8'($urandom); ln = 8'($urandom); rt = 8'($urandom); ct = 8'($urandom);
        os_req_i = 1'b1; os_type_i = 2'b01; link_pad_i = 1'b1; lane_pad_i = 1'b1;
        n_fts_i = nf; link_num_i = lk; lane_num_i = ln; rate_id_i = rt; train_ctrl_i = ct;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                os_req_i = 1'b0;
                n_fts_i = 8'($urandom); rate_id_i = 8'($urandom); train_ctrl_i = 8'($urandom);
                link_pad_i = 1'b0; lane_pad_i = 1'b0;
            end
            exp_beat = ts_beat(1'b1, nf, lk, ln, rt, ct, 1'b1, 1'b1, c - 1);
            checks++;
            if ({data_valid_o, data_k_out_o, data_out_o} !== {1'b1, exp_beat}) begin
                errors++;
                $display("[TB] FAIL ts2_pad_beat%0d: got v=%b k=%h d=%h expected v=1 k=%h d=%h",
                         c - 1, data_valid_o, data_k_out_o, data_out_o, exp_beat[35:32], exp_beat[31:0]);
            end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] pkt [6];
        logic [3:0]  pk  [6];
        int idx, pulses;
        go_active();
        for (int i = 0; i < 6; i++) begin
            pkt[i] = $urandom;
            pk[i]  = 4'($urandom);
        end
        idx = 0;
        pulses = 0;
        for (int it = 0; it < 8; it++) begin
            if (it == 3 || it == 4) begin
                data_valid_i = 1'b0; data_i = $urandom; data_last_i = 1'b0;
            end else begin
                data_valid_i = 1'b1; data_i = pkt[idx]; data_k_i = pk[idx]; data_last_i = (idx == 5);
            end
            #1;
            checks++;
            if (data_ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL uf_ready_it%0d: got %b expected 1", it, data_ready_o);
            end
            tick();
            if (underflow_o) pulses++;
            checks++;
            if (it == 3 || it == 4) begin
                if ({underflow_o, data_valid_o, data_k_out_o, data_out_o} !== {2'b11, 36'h0}) begin
                    errors++;
                    $display("[TB] FAIL uf_gap_it%0d: got uf=%b v=%b k=%h d=%h expected uf=1 v=1 k=0 d=0",
                             it, underflow_o, data_valid_o, data_k_out_o, data_out_o);
                end
            end else begin
                if ({underflow_o, data_valid_o, data_k_out_o, data_out_o} !== {2'b01, pk[idx], pkt[idx]}) begin
                    errors++;
                    $display("[TB] FAIL uf_beat%0d: got uf=%b v=%b k=%h d=%h expected uf=0 v=1 k=%h d=%h",
                             idx, underflow_o, data_valid_o, data_k_out_o, data_out_o, pk[idx], pkt[idx]);
                end
                idx++;
            end
        end
        data_valid_i = 1'b0; data_last_i = 1'b0;
        tick();
        checks++;
        if ({pulses, underflow_o, data_valid_o, data_k_out_o, data_out_o} !== {32'd2, 2'b01, 36'h0}) begin
            errors++;
            $display("[TB] FAIL uf_resume: got pulses=%0d uf=%b d=%h expected pulses=2 uf=0 d=0",
                     pulses, underflow_o, data_out_o);
        end
    endtask

    task automatic test_skp_idle();
        logic found, done, prev_rdy;
        int n, bad;
        go_active();
        wait_skp("skp_first", found);
        if (found) begin
            n = 0; bad = 0; done = 1'b0; prev_rdy = 1'b1;
            for (int i = 0; i < 400 && !done; i++) begin
                prev_rdy = data_ready_o;
                tick();
                if (data_valid_o && {data_k_out_o, data_out_o} == SKP_BEAT) begin
                    done = 1'b1;
                end else begin
                    n++;
                    if (!data_valid_o || {data_k_out_o, data_out_o} != IDLE_BEAT) bad++;
                end
            end
            checks++;
            if ({done, n, bad} !== {1'b1, 32'(SKP_GAP), 32'd0}) begin
                errors++;
                $display("[TB] FAIL skp_interval: got found=%b gap=%0d nonidle=%0d expected found=1 gap=%0d nonidle=0",
                         done, n, bad, SKP_GAP);
            end
            checks++;
            if (prev_rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL skp_ready_low: got %b expected 0", prev_rdy);
            end
        end
    endtask

    task automatic test_skp_mid_packet();
        logic found, acc;
        logic [31:0] pkt [40];
        logic [3:0]  pk  [40];
        int idx, bad, wait_k;
        go_active();
        wait_skp("midpkt_first_skp", found);
        if (found) begin
            for (int i = 0; i < 40; i++) begin
                pkt[i] = $urandom;
                pk[i]  = 4'($urandom);
            end
            wait_k = $urandom_range(260, 280);
            repeat (wait_k) tick();
            idx = 0; bad = 0;
            for (int it = 0; it < 100 && idx < 40; it++) begin
                data_valid_i = 1'b1; data_i = pkt[idx]; data_k_i = pk[idx]; data_last_i = (idx == 39);
                #1;
                acc = data_ready_o;
                tick();
                if (!acc) begin
                    bad++;
                end else begin
                    if ({data_valid_o, data_k_out_o, data_out_o} != {1'b1, pk[idx], pkt[idx]}) bad++;
                    idx++;
                end
            end
            data_valid_i = 1'b0; data_last_i = 1'b0;
            checks++;
            if ({idx, bad} !== {32'd40, 32'd0}) begin
                errors++;
                $display("[TB] FAIL midpkt_beats: got sent=%0d bad=%0d expected sent=40 bad=0", idx, bad);
            end
            #1;
            checks++;
            if (data_ready_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midpkt_ready: got %b expected 0", data_ready_o);
            end
            tick();
            checks++;
            if ({data_valid_o, data_k_out_o, data_out_o} !== {1'b1, SKP_BEAT}) begin
                errors++;
                $display("[TB] FAIL midpkt_skp_follows: got v=%b k=%h d=%h expected v=1 k=f d=1c1c1cbc",
                         data_valid_o, data_k_out_o, data_out_o);
            end
        end
    endtask

    task automatic test_eios();
        int bad, n;
        logic done;
        logic [7:0] nf, lk, ln, rt, ct;
        go_active();
        os_req_i = 1'b1; os_type_i = 2'b10;
        tick();
        os_req_i = 1'b0;
        checks++;
        if ({os_ack_o, data_valid_o, tx_elec_idle_o, data_k_out_o, data_out_o} !== {3'b110, EIOS_BEAT}) begin
            errors++;
            $display("[TB] FAIL eios_beat: got ack=%b v=%b ei=%b k=%h d=%h expected ack=1 v=1 ei=0 k=f d=7c7c7cbc",
                     os_ack_o, data_valid_o, tx_elec_idle_o, data_k_out_o, data_out_o);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if ({data_valid_o, tx_elec_idle_o, os_ack_o, data_ready_o} != 4'b0100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL eios_enter_ei: got %0d bad cycles expected 0", bad);
        end
        os_req_i = 1'b1; os_type_i = 2'b10;
        tick();
        os_req_i = 1'b0;
        checks++;
        if ({os_ack_o, data_valid_o, tx_elec_idle_o} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL eios_in_ei: got ack=%b v=%b ei=%b expected ack=1 v=0 ei=1",
                     os_ack_o, data_valid_o, tx_elec_idle_o);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if ({data_valid_o, tx_elec_idle_o, os_ack_o} != 3'b010) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL ei_hold: got %0d bad cycles expected 0", bad);
        end
        nf = 8'($urandom); lk = 8'($urandom); ln = 8'($urandom); rt = 8'($urandom); ct = 8'($urandom);
        os_req_i = 1'b1; os_type_i = 2'b00;
        n_fts_i = nf; link_num_i = lk; lane_num_i = ln; rate_id_i = rt; train_ctrl_i = ct;
        tick();
        os_req_i = 1'b0;
        checks++;
        if ({os_ack_o, data_valid_o, tx_elec_idle_o, data_k_out_o, data_out_o}
            !== {3'b110, ts_beat(1'b0, nf, lk, ln, rt, ct, 1'b0, 1'b0, 0)}) begin
            errors++;
            $display("[TB] FAIL ei_exit_ts1: got ack=%b v=%b ei=%b k=%h d=%h expected ack=1 v=1 ei=0 beat0",
                     os_ack_o, data_valid_o, tx_elec_idle_o, data_k_out_o, data_out_o);
        end
        // Counter restarted from zero in EI: first SKP is output beat 296 counting beat0 as 1.
        n = 1; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            n++;
            if (data_valid_o && {data_k_out_o, data_out_o} == SKP_BEAT) done = 1'b1;
        end
        checks++;
        if ({done, n} !== {1'b1, 32'(SKP_GAP + 1)}) begin
            errors++;
            $display("[TB] FAIL ei_skp_restart: got found=%b beat=%0d expected found=1 beat=%0d", done, n, SKP_GAP + 1);
        end
    endtask

    task automatic test_reserved();
        int acks, bad;
        go_active();
        os_req_i = 1'b1; os_type_i = 2'b11;
        acks = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (os_ack_o) acks++;
            if ({data_valid_o, data_k_out_o, data_out_o} != {1'b1, IDLE_BEAT}) bad++;
        end
        os_req_i = 1'b0;
        checks++;
        if ({acks, bad} !== {32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reserved_type: got acks=%0d nonidle=%0d expected 0 0", acks, bad);
        end
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_back_to_back();
        test_ts2_pad();
        test_underflow();
        test_skp_idle();
        test_skp_mid_packet();
        test_eios();
        test_reserved();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen1_tx_scheduler.md
# gen1_tx_scheduler

Gen1/Gen2 transmit symbol scheduler that sits directly upstream of the gen1 scrambler. It shares the scrambler input between three requesters: link-layer packet beats, LTSSM ordered-set requests (TS1/TS2/EIOS) and internally timed SKP ordered sets. It emits logical idle when none of them has anything to send. It produces 4 symbols per cycle (32-bit, byte 0 transmitted first) with matching K flags.

## Interface
- SKP_INTERVAL, 1180: symbols between SKP ordered sets. Must be a multiple of 4 in the range 4..2044.
- clk_i  in  1  datapath clock
- rst_i  in  1  reset; one clock; synchronous, active-high
- data_i  in  32  link-layer beat
- data_k_i  in  4  K flags for data_i
- data_valid_i  in  1  beat valid
- data_last_i  in  1  final beat of a packet
- data_ready_o  out  1  beat accepted when valid&ready
- os_req_i  in  1  ordered-set request; held until os_ack_o
- os_type_i  in  2  00 TS1, 01 TS2, 10 EIOS, 11 reserved
- link_num_i, lane_num_i, n_fts_i, rate_id_i, train_ctrl_i  in  8 each  TS fields
- link_pad_i, lane_pad_i  in  1 each  send PAD (K23.7) instead of the link/lane number
- os_ack_o  out  1  one-cycle pulse, aligned with the first output beat of the OS
- data_out_o  out  32  to scrambler data_in_i
- data_k_out_o  out  4  to scrambler data_k_in_i
- data_valid_o  out  1  to scrambler data_valid_i
- tx_elec_idle_o  out  1  transmitter in electrical idle
- underflow_o  out  1  pulse: data_valid_i was low inside a packet

## Operation
- Symbols: COM=0xBC (K), SKP=0x1C (K), IDL=0x7C (K), PAD=0xF7 (K), TS1 ID=0x4A, TS2 ID=0x45, logical idle=0x00 (D).
- States: EI, IDLE, DATA, TS (4 beats, beat counter 0..3), SKP (1 beat), EIOS (1 beat).
- Boundary cycle: the next-beat selection point. It occurs while in IDLE, and on the last beat of DATA (data_last_i accepted), TS (beat 3), SKP and EIOS.
- Priority at a boundary: skp_pending > os_req_i > data_valid_i > logical idle.
- data_ready_o, combinational:
  - 1 in DATA.
  - 1 in IDLE when !skp_pending && !os_req_i.
  - 0 otherwise.
- DATA: a beat passes through unchanged. If data_valid_i=0, emit 0x00000000 with k=0, pulse underflow_o and stay in DATA.
- TS beats (byte 0 in bits [7:0]):
  - beat0 = {n_fts, lane|PAD, link|PAD, COM}, k={0,lane_pad,link_pad,1}.
  - beat1 = {ID, ID, train_ctrl, rate_id}, k=0.
  - beats 2–3 = {ID×4}, k=0.
- TS fields are captured in the selection cycle.
- SKP beat = 0x1C1C1CBC, k=4'hF. EIOS beat = 0x7C7C7CBC, k=4'hF.
- EIOS flow: after the EIOS beat, go to EI.
  - In EI: data_valid_o=0, tx_elec_idle_o=1, data_ready_o=0.
  - A TS1/TS2 request in EI is acked and its beat0 leaves EI.
  - An EIOS request in EI is acked and nothing is sent.
- os_type_i=11: never acked, ignored.
- SKP counter (11-bit, saturating at 2047):
  - +4 for every output beat with data_valid_o=1, excluding SKP beats.
  - Cleared when a SKP beat is emitted, and while in EI.
  - skp_pending = (cnt >= SKP_INTERVAL).

## Timing
- All outputs except data_ready_o are registered.
- Latency: data beat accepted in cycle n appears on data_out_o in cycle n+1.
- OS selected in cycle n: os_ack_o and beat0 at n+1; TS beats at n+1..n+4.
- A held os_req_i yields back-to-back TS sets with no gap; the next ack comes at n+5.
- Output is continuous (data_valid_o=1 every cycle) outside EI.
- Reset values:
  - state EI, cnt 0.
  - data_out_o 0, data_k_out_o 0, data_valid_o 0.
  - tx_elec_idle_o 1, os_ack_o 0, underflow_o 0, data_ready_o 0.
- Reset mid-OS or mid-packet: the partial set is abandoned with no ack; return to EI.
- Simultaneous SKP pending and os_req_i at a boundary: SKP first, the OS at the following boundary.
- data_last_i beat accepted while pending: the SKP beat follows immediately.
- SKP is never inserted inside a packet or a TS set; it waits for the boundary.

## Test plan
- Reset, then os_req_i TS1 (link 0x05, lane 0x02, n_fts 0x10, rate 0x02, ctrl 0) held for 2 sets -> ack pulses at beats 0 and 4. Beat0 = 0x100205BC, k=1. Beats 2–3 = 0x4A4A4A4A. tx_elec_idle_o falls with the first beat.
- TS2 with link_pad_i=lane_pad_i=1 -> beat0 = {n_fts, F7, F7, BC}, k=4'b0111. Beats 2–3 = 0x45454545.
- Idle link with SKP_INTERVAL=1180 -> a SKP beat 0x1C1C1CBC every 296th output beat (295 idle beats between).
- SKP count expires mid-packet -> the SKP beat follows the data_last_i beat directly; data_ready_o is low that cycle; no packet beat is split or lost.
- data_valid_i dropped mid-packet for 2 cycles -> two 0x00000000 beats, underflow_o pulses twice, the packet then resumes.
- EIOS request -> one 0x7C7C7CBC beat, then data_valid_o=0 and tx_elec_idle_o=1. The SKP counter stays 0 until a TS1 request exits EI.
